echo_indication_m2p: RTL and testbench

Method-to-pipe marshaller for the echo interface: it accepts `say2`, `say` and `setLeds` method calls and serialises each into one 128-bit pipe word. The word layout is the one the pipe-to-method demux on the far end decodes. It sits between the user logic that issues echo indications and the outbound pipe (host transport / loopback). Each method has a one-entry pending slot, a round-robin arbiter drains the slots, and a 2-deep FIFO absorbs pipe backpressure.

---
 rtl/echo_pkg.sv | 32 +++
 rtl/m2p_fifo.sv | 50 +++++
 rtl/echo_indication_m2p.sv | 117 +++++++++++
 tb/tb_echo_indication_m2p.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared definitions for the echo interface pipe word.
// The far-end pipe-to-method demux imports this same package.
package echo_pkg;

   localparam int unsigned PIPE_WIDTH     = 128;
   localparam int unsigned ID_OFFSET      = 16;
   localparam int unsigned PAYLOAD_OFFSET = 32;
   localparam int unsigned PAYLOAD_WIDTH  = PIPE_WIDTH - PAYLOAD_OFFSET;

   localparam logic [15:0] WORD_COUNT = 16'd2;

   localparam logic [15:0] SAY2    = 16'd0;
   localparam logic [15:0] SAY     = 16'd1;
   localparam logic [15:0] SETLEDS = 16'd2;

   typedef enum logic [1:0] {
      MethSay2,
      MethSay,
      MethSetLeds
   } meth_e;

   function automatic logic [PIPE_WIDTH-1:0] pack_word(input logic [15:0] id,
                                                       input logic [PAYLOAD_WIDTH-1:0] payload);
      logic [PIPE_WIDTH-1:0] w;
      w = '0;
      w[15:0] = WORD_COUNT;
      w[ID_OFFSET +: 16] = id;
      w[PAYLOAD_OFFSET +: PAYLOAD_WIDTH] = payload;
      return w;
   endfunction

endpackage

// File: rtl/m2p_fifo.sv
// Small synchronous FIFO with head-of-queue output; a push is accepted when
// full only if a pop happens in the same cycle.
module m2p_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/echo_indication_m2p.sv
// Echo method-to-pipe marshaller: one pending slot per method, round-robin
// drain into a small output FIFO feeding the outbound pipe.
module echo_indication_m2p
   import echo_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         method_say2__ENA,
   input  logic [15:0]  method_say2_a,
   input  logic [15:0]  method_say2_b,
   output logic         method_say2__RDY,
   input  logic         method_say__ENA,
   input  logic [31:0]  method_say_v,
   output logic         method_say__RDY,
   input  logic         method_setLeds__ENA,
   input  logic [7:0]   method_setLeds_v,
   output logic         method_setLeds__RDY,
   output logic         pipe_enq__ENA,
   output logic [127:0] pipe_enq_v,
   input  logic         pipe_enq__RDY
);

   logic        say2_vld_q, say_vld_q, leds_vld_q;
   logic [15:0] say2_a_q, say2_b_q;
   logic [31:0] say_v_q;
   logic [7:0]  leds_v_q;
   meth_e       ptr_q, ptr_d;

   logic [2:0]            pend, gnt;
   logic                  can_grant, enq_ena, fifo_full, fifo_empty;
   logic [PIPE_WIDTH-1:0] push_word, head_word;

   assign pend      = {leds_vld_q, say_vld_q, say2_vld_q};
   assign enq_ena   = ~fifo_empty & pipe_enq__RDY;
   // A pop this cycle frees the entry the grant will fill.
   assign can_grant = ~fifo_full | enq_ena;

   always_comb begin
      gnt = 3'b000;
      if (can_grant) begin
         case (ptr_q)
            MethSay2:    gnt = pend[0] ? 3'b001 : pend[1] ? 3'b010 : pend[2] ? 3'b100 : 3'b000;
            MethSay:     gnt = pend[1] ? 3'b010 : pend[2] ? 3'b100 : pend[0] ? 3'b001 : 3'b000;
            MethSetLeds: gnt = pend[2] ? 3'b100 : pend[0] ? 3'b001 : pend[1] ? 3'b010 : 3'b000;
            default:     gnt = 3'b000;
         endcase
      end
      ptr_d = ptr_q;
      if (gnt[0])      ptr_d = MethSay;
      else if (gnt[1]) ptr_d = MethSetLeds;
      else if (gnt[2]) ptr_d = MethSay2;
   end

   always_comb begin
      push_word = '0;
      if (gnt[0])      push_word = pack_word(SAY2, PAYLOAD_WIDTH'({say2_b_q, say2_a_q}));
      else if (gnt[1]) push_word = pack_word(SAY, PAYLOAD_WIDTH'(say_v_q));
      else if (gnt[2]) push_word = pack_word(SETLEDS, PAYLOAD_WIDTH'(leds_v_q));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         say2_vld_q <= 1'b0;
         say_vld_q  <= 1'b0;
         leds_vld_q <= 1'b0;
         say2_a_q   <= '0;
         say2_b_q   <= '0;
         say_v_q    <= '0;
         leds_v_q   <= '0;
         ptr_q      <= MethSay2;
      end else begin
         ptr_q <= ptr_d;
         if (gnt[0]) begin
            say2_vld_q <= 1'b0;
         end else if (method_say2__ENA && !say2_vld_q) begin
            say2_vld_q <= 1'b1;
            say2_a_q   <= method_say2_a;
            say2_b_q   <= method_say2_b;
         end
         if (gnt[1]) begin
            say_vld_q <= 1'b0;
         end else if (method_say__ENA && !say_vld_q) begin
            say_vld_q <= 1'b1;
            say_v_q   <= method_say_v;
         end
         if (gnt[2]) begin
            leds_vld_q <= 1'b0;
         end else if (method_setLeds__ENA && !leds_vld_q) begin
            leds_vld_q <= 1'b1;
            leds_v_q   <= method_setLeds_v;
         end
      end
   end

   m2p_fifo #(
      .WIDTH (PIPE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (|gnt),
      .data_i  (push_word),
      .pop_i   (enq_ena),
      .data_o  (head_word),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign method_say2__RDY    = ~say2_vld_q;
   assign method_say__RDY     = ~say_vld_q;
   assign method_setLeds__RDY = ~leds_vld_q;
   assign pipe_enq__ENA       = enq_ena;
   assign pipe_enq_v          = head_word;

endmodule

// File: tb/tb_echo_indication_m2p.sv
// Scoreboard bench for echo_indication_m2p: expected words are queued when a
// call is accepted and compared as words leave on the pipe.
module tb_echo_indication_m2p;

   logic         CLK = 1'b0;
   logic         RST;
   logic         say2_ena, say_ena, leds_ena;
   logic [15:0]  say2_a, say2_b;
   logic [31:0]  say_v;
   logic [7:0]   leds_v;
   logic         say2_rdy, say_rdy, leds_rdy;
   logic         pipe_ena, pipe_rdy;
   logic [127:0] pipe_v;

   int total = 0;
   int bad = 0;
   int nword = 0;
   logic [127:0] exp_q[$];

   always #5 CLK = ~CLK;

   echo_indication_m2p #(
      .FIFO_DEPTH (2)
   ) dut (
      .CLK                 (CLK),
      .RST                 (RST),
      .method_say2__ENA    (say2_ena),
      .method_say2_a       (say2_a),
      .method_say2_b       (say2_b),
      .method_say2__RDY    (say2_rdy),
      .method_say__ENA     (say_ena),
      .method_say_v        (say_v),
      .method_say__RDY     (say_rdy),
      .method_setLeds__ENA (leds_ena),
      .method_setLeds_v    (leds_v),
      .method_setLeds__RDY (leds_rdy),
      .pipe_enq__ENA       (pipe_ena),
      .pipe_enq_v          (pipe_v),
      .pipe_enq__RDY       (pipe_rdy)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] w_say2(input logic [15:0] a, input logic [15:0] b);
      return {64'h0, b, a, 16'h0000, 16'h0002};
   endfunction

   function automatic logic [127:0] w_say(input logic [31:0] v);
      return {64'h0, v, 16'h0001, 16'h0002};
   endfunction

   function automatic logic [127:0] w_leds(input logic [7:0] v);
      return {88'h0, v, 16'h0002, 16'h0002};
   endfunction

   function automatic logic rdy_of(input int m);
      case (m)
         0:       return say2_rdy;
         1:       return say_rdy;
         default: return leds_rdy;
      endcase
   endfunction

   // Output monitor: every transferred word must match the queue head.
   always @(negedge CLK) begin
      if (!RST && pipe_ena) begin
         if (exp_q.size() == 0) check("extra_word", {127'h0, pipe_ena}, 128'h0);
         else check($sformatf("word%0d", nword), pipe_v, exp_q.pop_front());
         nword++;
      end
   end

   task automatic clear_ena();
      say2_ena = 1'b0;
      say_ena  = 1'b0;
      leds_ena = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      clear_ena();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      exp_q.delete();
   endtask

   // One method call: wait for RDY at a falling edge, then strobe for one cycle.
   task automatic call(input int m, input logic [31:0] d);
      int n = 0;
      @(negedge CLK);
      while (!rdy_of(m) && n < 20) begin
         @(negedge CLK);
         n++;
      end
      if (n == 20) begin
         check($sformatf("call%0d_rdy_timeout", m), {127'h0, rdy_of(m)}, 128'h1);
         return;
      end
      case (m)
         0: begin
            say2_ena = 1'b1; say2_a = d[15:0]; say2_b = d[31:16];
            exp_q.push_back(w_say2(d[15:0], d[31:16]));
         end
         1: begin
            say_ena = 1'b1; say_v = d;
            exp_q.push_back(w_say(d));
         end
         default: begin
            leds_ena = 1'b1; leds_v = d[7:0];
            exp_q.push_back(w_leds(d[7:0]));
         end
      endcase
      @(posedge CLK);
      #1;
      clear_ena();
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge CLK);
         n++;
      end
      check("drain_left", 128'(exp_q.size()), 128'h0);
      repeat (4) @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int ns, nl;
      RST = 1'b1; pipe_rdy = 1'b1;
      say2_a = '0; say2_b = '0; say_v = '0; leds_v = '0;
      clear_ena();
      do_reset();

      // Reset state and single-call latency
      @(negedge CLK);
      check("rst_say2_rdy", {127'h0, say2_rdy}, 128'h1);
      check("rst_say_rdy", {127'h0, say_rdy}, 128'h1);
      check("rst_leds_rdy", {127'h0, leds_rdy}, 128'h1);
      check("rst_enq_ena", {127'h0, pipe_ena}, 128'h0);
      check("rst_enq_v", pipe_v, 128'h0);
      say_ena = 1'b1; say_v = 32'hDEADBEEF;
      exp_q.push_back(128'h0000_0000_0000_0000_DEADBEEF_0001_0002);
      @(posedge CLK); #1; clear_ena();
      @(negedge CLK);
      check("lat_n1_say_rdy", {127'h0, say_rdy}, 128'h0);
      check("lat_n1_ena", {127'h0, pipe_ena}, 128'h0);
      @(negedge CLK);
      check("lat_n2_say_rdy", {127'h0, say_rdy}, 128'h1);
      check("lat_n2_ena", {127'h0, pipe_ena}, 128'h1);
      @(negedge CLK);
      check("lat_n3_ena", {127'h0, pipe_ena}, 128'h0);
      drain();

      // Same-cycle calls on all three methods
      do_reset();
      @(negedge CLK);
      say2_ena = 1'b1; say2_a = 16'h1234; say2_b = 16'h5678;
      say_ena = 1'b1; say_v = 32'h1;
      leds_ena = 1'b1; leds_v = 8'hA5;
      exp_q.push_back(w_say2(16'h1234, 16'h5678));
      exp_q.push_back(w_say(32'h1));
      exp_q.push_back(w_leds(8'hA5));
      @(posedge CLK); #1; clear_ena();
      @(negedge CLK);
      check("b2b_gap", {127'h0, pipe_ena}, 128'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check($sformatf("b2b_ena%0d", i), {127'h0, pipe_ena}, 128'h1);
      end
      drain();

      // Backpressure: FIFO fills, slots stay pending until the pipe opens
      do_reset();
      pipe_rdy = 1'b0;
      call(0, 32'hBBBB_AAAA);
      call(1, 32'h0000_0011);
      call(2, 32'h0000_0022);
      call(0, 32'hDDDD_CCCC);
      call(1, 32'h0000_0033);
      @(negedge CLK);
      check("bp_say2_rdy", {127'h0, say2_rdy}, 128'h0);
      check("bp_say_rdy", {127'h0, say_rdy}, 128'h0);
      check("bp_leds_rdy", {127'h0, leds_rdy}, 128'h0);
      check("bp_enq_ena", {127'h0, pipe_ena}, 128'h0);
      repeat (3) @(negedge CLK);
      check("bp_hold_say_rdy", {127'h0, say_rdy}, 128'h0);
      @(posedge CLK); #1;
      pipe_rdy = 1'b1;
      call(2, 32'h0000_0044);
      drain();

      // Fairness: say and setLeds re-called whenever ready
      do_reset();
      ns = 0; nl = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge CLK);
         if (say_rdy && ns < 8) begin
            say_ena = 1'b1; say_v = 32'h100 + 32'(ns);
            exp_q.push_back(w_say(32'h100 + 32'(ns)));
            ns++;
         end
         if (leds_rdy && nl < 8) begin
            leds_ena = 1'b1; leds_v = 8'h50 + 8'(nl);
            exp_q.push_back(w_leds(8'h50 + 8'(nl)));
            nl++;
         end
         @(posedge CLK); #1; clear_ena();
      end
      check("fair_say_calls", 128'(ns), 128'd8);
      check("fair_leds_calls", 128'(nl), 128'd8);
      drain();

      // Reset mid-operation with FIFO full and a slot pending
      do_reset();
      pipe_rdy = 1'b0;
      call(0, 32'h0202_0101);
      call(1, 32'h0000_0303);
      call(2, 32'h0000_0004);
      repeat (2) @(posedge CLK);
      #2;
      RST = 1'b1;
      pipe_rdy = 1'b1;
      exp_q.delete();
      #1;
      check("mid_rst_enq_ena", {127'h0, pipe_ena}, 128'h0);
      check("mid_rst_say2_rdy", {127'h0, say2_rdy}, 128'h1);
      check("mid_rst_say_rdy", {127'h0, say_rdy}, 128'h1);
      check("mid_rst_leds_rdy", {127'h0, leds_rdy}, 128'h1);
      say_ena = 1'b1; say_v = 32'hFFFF_FFFF;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      say_ena = 1'b0;
      @(negedge CLK);
      check("post_rst_say_rdy", {127'h0, say_rdy}, 128'h1);
      check("post_rst_enq_ena", {127'h0, pipe_ena}, 128'h0);
      call(2, 32'h0000_003C);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
